multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the team's MIPS datapath in multicycle form: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- Replaces the single-cycle combinational control unit, so one ALU and one unified instruction/data memory are shared across cycles.
- Adds a memory-ready handshake so the memory may take more than one cycle.
- Sits between the instruction register opcode field and the datapath muxes, enables and write strobes.

Parameters:
- STATE_W, 4, width of the state register and of the state debug output.
- MAX_WAIT, 15, number of cycles a memory state waits for MemReady before flagging a timeout.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  instruction bits 31:26, taken from the instruction register.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory has completed the current access this cycle.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut register.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by Zero (branch).
- PCSrc  output  2  PC source: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- ALUSrcA  output  1  ALU A operand: 0 = PC, 1 = register A.
- ALUSrcB  output  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  output  2  to the ALU decoder: 00 = add, 01 = sub, 10 = use funct.
- RegWrite  output  1  register file write enable.
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  register write address: 0 = rt, 1 = rd.
- Retire  output  1  one-cycle pulse when an instruction completes.
- Illegal  output  1  one-cycle pulse on an unsupported opcode in DECODE.
- Timeout  output  1  sticky flag, set when a memory state waits past MAX_WAIT; cleared only by rst.
- State  output  STATE_W  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable; any of them returns to FETCH on the next edge.
- Reset: on a CLK edge with rst=1:
  - state goes to FETCH; the wait counter, Timeout, Retire and Illegal clear to 0.
  - While in reset all write strobes (MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite) are 0.
  - rst mid-instruction abandons it with no register or memory write.
- Outputs are a decode of the registered state, except the MemReady-qualified strobes noted below. Any signal not listed for a state is 0.
- FETCH:
  - Asserted: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite assert only when MemReady=1; advance to DECODE on MemReady=1, otherwise stay.
- DECODE:
  - Asserted: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode -> FETCH with Illegal=1 for one cycle; PC has already advanced by 4.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold until MemReady=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; Retire=1; next FETCH.
- MEMWR: IorD=1; MemWrite asserts only when MemReady=1. Hold until MemReady=1, then FETCH with Retire=1 in the completing cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; Retire=1; next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01; Retire=1; next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; Retire=1; next FETCH.
- JUMP: PCWrite=1, PCSrc=10; Retire=1; next FETCH.
- CPI: R-type 4, addi 4, beq 3, j 3, sw 4, lw 5, each with zero memory wait. Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Wait counter:
  - 4 bits; increments each cycle in a memory state with MemReady=0; clears on leaving the state or on MemReady=1.
  - Reaching MAX_WAIT sets Timeout. The FSM keeps waiting; there is no forced exit.
- MemReady arriving in the same cycle the state is entered completes the access that cycle (zero-wait).

Test Plan:
- rst=1 for 2 cycles, then release -> State=0, IRWrite=PCWrite=RegWrite=MemWrite=0 during reset; MemRead=1, IorD=0, ALUSrcB=01 once rst=0.
- MemReady tied 1, opcode=000000 -> states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; Retire pulses once; 4 cycles.
- opcode=100011, MemReady low 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; IorD=1 throughout MEMRD; MemtoReg=1 in MEMWB; 8 cycles.
- opcode=101011, MemReady=0 for 16 cycles in MEMWR -> Timeout=1 and held after MemReady=1; MemWrite=1 only in the cycle MemReady=1; Timeout cleared only by rst.
- opcode=000100 with Zero=1, then opcode=000010 -> BRANCH: PCWriteCond=1, PCSrc=01, ALUOp=01. JUMP: PCWrite=1, PCSrc=10. Each instruction takes 3 cycles.
- opcode=111111 -> DECODE to FETCH, Illegal=1 for exactly one cycle, no RegWrite/MemWrite; rst asserted in MEMRD -> FETCH next edge, RegWrite never asserted.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// over a shared ALU and unified memory, with a MemReady wait handshake and timeout flag.
module multicycle_ctrl #(
  parameter int STATE_W  = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               Retire,
  output logic               Illegal,
  output logic               Timeout,
  output logic [STATE_W-1:0] State
);

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXEC   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_ADDIEX = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_ADDIWB = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;

  logic               mem_state;
  logic               waiting;

  // Raw per-state decode before reset gating of strobes.
  logic               iord_c, memread_c, memwrite_c, irwrite_c;
  logic               pcwrite_c, pcwritecond_c;
  logic [1:0]         pcsrc_c, alusrcb_c, aluop_c;
  logic               alusrca_c, regwrite_c, memtoreg_c, regdst_c;
  logic               retire_c, illegal_c;

  // Branch qualification by Zero is done in the datapath PC-enable logic.
  logic               zero_unused;
  assign zero_unused = Zero;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                     (state_q == S_MEMWR);
  assign waiting   = mem_state && !MemReady;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Counter saturates so a very long stall cannot wrap back below the limit.
  always_comb begin
    wait_cnt_d = 4'd0;
    timeout_d  = timeout_q;
    if (waiting) begin
      wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
      if (wait_cnt_q >= WAIT_LIMIT - 4'd1) begin
        timeout_d = 1'b1;
      end
    end
    if (state_d != state_q) begin
      wait_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 4'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    iord_c        = 1'b0;
    memread_c     = 1'b0;
    memwrite_c    = 1'b0;
    irwrite_c     = 1'b0;
    pcwrite_c     = 1'b0;
    pcwritecond_c = 1'b0;
    pcsrc_c       = 2'b00;
    alusrca_c     = 1'b0;
    alusrcb_c     = 2'b00;
    aluop_c       = 2'b00;
    regwrite_c    = 1'b0;
    memtoreg_c    = 1'b0;
    regdst_c      = 1'b0;
    retire_c      = 1'b0;
    illegal_c     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = 2'b01;
        irwrite_c = MemReady;
        pcwrite_c = MemReady;
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        unique case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_c = 1'b0;
          default:                                      illegal_c = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
      end
      S_MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
        retire_c   = 1'b1;
      end
      S_MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = MemReady;
        retire_c   = MemReady;
      end
      S_EXEC: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b10;
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        regdst_c   = 1'b1;
        retire_c   = 1'b1;
      end
      S_BRANCH: begin
        alusrca_c     = 1'b1;
        aluop_c       = 2'b01;
        pcwritecond_c = 1'b1;
        pcsrc_c       = 2'b01;
        retire_c      = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        retire_c   = 1'b1;
      end
      S_JUMP: begin
        pcwrite_c = 1'b1;
        pcsrc_c   = 2'b10;
        retire_c  = 1'b1;
      end
      default: begin
        memread_c = 1'b0;
      end
    endcase
  end

  // Strobes are forced low during reset so an abandoned instruction writes nothing.
  assign MemWrite    = memwrite_c    && !rst;
  assign IRWrite     = irwrite_c     && !rst;
  assign PCWrite     = pcwrite_c     && !rst;
  assign PCWriteCond = pcwritecond_c && !rst;
  assign RegWrite    = regwrite_c    && !rst;
  assign Retire      = retire_c      && !rst;
  assign Illegal     = illegal_c     && !rst;

  assign IorD     = iord_c;
  assign MemRead  = memread_c;
  assign PCSrc    = pcsrc_c;
  assign ALUSrcA  = alusrca_c;
  assign ALUSrcB  = alusrcb_c;
  assign ALUOp    = aluop_c;
  assign MemtoReg = memtoreg_c;
  assign RegDst   = regdst_c;
  assign Timeout  = timeout_q;
  assign State    = state_q;

endmodule
